// File: rtl/mac_issue_seq.sv
// Issue sequencer and vector accumulator in front of the 16-multiplier MAC array.
// Beats are registered onto the MAC inputs, results are summed per vector and held until taken.
module mac_issue_seq #(
  parameter int INWID   = 4,
  parameter int OUT_BIT = 32,
  parameter int ACC_BIT = 40,
  parameter int CNT_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_code,
  input  logic [INWID*4-1:0]   in_a,
  input  logic [INWID*4-1:0]   in_b,
  input  logic                 in_last,
  output logic [1:0]           mac_ctrl,
  output logic [INWID*4-1:0]   mac_a,
  output logic [INWID*4-1:0]   mac_b,
  input  logic [OUT_BIT-1:0]   mac_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ACC_BIT-1:0]   res_data,
  output logic [CNT_BIT-1:0]   res_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                       accept;
  logic                       vld_p1;
  logic                       last_p1;
  logic signed [ACC_BIT-1:0]  acc_p2;
  logic signed [ACC_BIT-1:0]  acc_nxt;
  logic [CNT_BIT-1:0]         cnt_p2;
  logic [CNT_BIT-1:0]         cnt_nxt;
  logic [ACC_BIT-1:0]         res_data_q;
  logic [CNT_BIT-1:0]         res_count_q;

  // Negations come back from the MAC as signed values, products as unsigned magnitudes.
  function automatic logic signed [ACC_BIT-1:0] ext_term(input logic [1:0]         code,
                                                        input logic [OUT_BIT-1:0] val);
    logic signed [OUT_BIT-1:0] sval;
    logic signed [ACC_BIT-1:0] term;
    sval = signed'(val);
    case (code)
      2'b01, 2'b10: term = ACC_BIT'(sval);
      2'b11:        term = signed'(ACC_BIT'(val));
      default:      term = '0;
    endcase
    return term;
  endfunction

  function automatic logic [CNT_BIT-1:0] sat_inc(input logic [CNT_BIT-1:0] c);
    return (&c) ? c : c + CNT_BIT'(1);
  endfunction

  assign accept    = in_valid && in_ready;
  assign in_ready  = reset && (state == RUN);
  assign res_valid = reset && (state == HOLD);
  assign res_data  = res_data_q;
  assign res_count = res_count_q;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (accept && in_last) state_nxt = FLUSH;
      FLUSH:   if (vld_p1 && last_p1) state_nxt = HOLD;
      HOLD:    if (res_ready)         state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // p1: issue stage, MAC inputs driven straight from these registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= RUN;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      mac_ctrl <= '0;
      mac_a    <= '0;
      mac_b    <= '0;
    end else begin
      state   <= state_nxt;
      vld_p1  <= accept;
      last_p1 <= accept && in_last;
      if (accept) begin
        mac_ctrl <= in_code;
        mac_a    <= in_a;
        mac_b    <= in_b;
      end else begin
        mac_ctrl <= '0;
        mac_a    <= '0;
        mac_b    <= '0;
      end
    end
  end

  // p2: accumulate the MAC result of the beat currently in p1
  always_comb begin
    acc_nxt = acc_p2;
    cnt_nxt = cnt_p2;
    if (vld_p1) begin
      acc_nxt = acc_p2 + ext_term(mac_ctrl, mac_out);
      cnt_nxt = sat_inc(cnt_p2);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_p2      <= '0;
      cnt_p2      <= '0;
      res_data_q  <= '0;
      res_count_q <= '0;
    end else begin
      if ((state == HOLD) && res_ready) begin
        acc_p2 <= '0;
        cnt_p2 <= '0;
      end else begin
        acc_p2 <= acc_nxt;
        cnt_p2 <= cnt_nxt;
      end
      // Result registers keep the last vector after the handshake clears the accumulator.
      if ((state == FLUSH) && (state_nxt == HOLD)) begin
        res_data_q  <= acc_nxt;
        res_count_q <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mac_issue_seq.sv
// Bench for mac_issue_seq: directed vectors plus random traffic against a vector-sum reference model.
module tb_mac_issue_seq;
  localparam int INWID   = 4;
  localparam int OP_W    = INWID * 4;
  localparam int OUT_BIT = 32;
  localparam int ACC_BIT = 40;
  localparam int CNT_BIT = 16;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_code;
  logic [OP_W-1:0]    in_a;
  logic [OP_W-1:0]    in_b;
  logic               in_last;
  logic [1:0]         mac_ctrl;
  logic [OP_W-1:0]    mac_a;
  logic [OP_W-1:0]    mac_b;
  logic [OUT_BIT-1:0] mac_out;
  logic               res_valid;
  logic               res_ready;
  logic [ACC_BIT-1:0] res_data;
  logic [CNT_BIT-1:0] res_count;

  mac_issue_seq #(
    .INWID(INWID), .OUT_BIT(OUT_BIT), .ACC_BIT(ACC_BIT), .CNT_BIT(CNT_BIT)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mac_ctrl(mac_ctrl), .mac_a(mac_a), .mac_b(mac_b), .mac_out(mac_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_count(res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC array: zero, +a, -a (two's complement), a*b.
  always_comb begin
    case (mac_ctrl)
      2'b01:   mac_out = OUT_BIT'(mac_a);
      2'b10:   mac_out = OUT_BIT'(0) - OUT_BIT'(mac_a);
      2'b11:   mac_out = OUT_BIT'(mac_a) * OUT_BIT'(mac_b);
      default: mac_out = '0;
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: vector sums as plain modular arithmetic on the accepted beats.
  typedef struct {
    logic [ACC_BIT-1:0] data;
    logic [CNT_BIT-1:0] cnt;
  } res_t;

  res_t               m_q[$];
  logic [ACC_BIT-1:0] m_sum = '0;
  logic [CNT_BIT-1:0] m_cnt = '0;
  logic [ACC_BIT-1:0] m_hold_data = '0;
  logic [CNT_BIT-1:0] m_hold_cnt = '0;
  bit                 pending = 1'b0;
  int                 cyc = 0;
  int                 last_cyc = 0;

  function automatic logic [ACC_BIT-1:0] term_of(input logic [1:0] c,
                                                input logic [OP_W-1:0] a,
                                                input logic [OP_W-1:0] b);
    case (c)
      2'b01:   return ACC_BIT'(a);
      2'b10:   return ACC_BIT'(0) - ACC_BIT'(a);
      2'b11:   return ACC_BIT'(a) * ACC_BIT'(b);
      default: return '0;
    endcase
  endfunction

  // Inputs change #1 after posedge; everything is observed here at negedge.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_res_valid", 64'(res_valid), 64'(0));
      m_q.delete();
      m_sum = '0;
      m_cnt = '0;
      m_hold_data = '0;
      m_hold_cnt = '0;
      pending = 1'b0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(!pending));
      chk("res_valid", 64'(res_valid), 64'(pending && (cyc - last_cyc >= 2)));
      if (res_valid) begin
        if (m_q.size() == 0) begin
          chk("unexpected_result", 64'(1), 64'(0));
        end else begin
          chk("res_data", 64'(res_data), 64'(m_q[0].data));
          chk("res_count", 64'(res_count), 64'(m_q[0].cnt));
          m_hold_data = m_q[0].data;
          m_hold_cnt  = m_q[0].cnt;
          if (res_ready) begin
            void'(m_q.pop_front());
            pending = 1'b0;
          end
        end
      end else begin
        chk("idle_res_data", 64'(res_data), 64'(m_hold_data));
        chk("idle_res_count", 64'(res_count), 64'(m_hold_cnt));
      end
      if (in_valid && in_ready) begin
        m_sum = m_sum + term_of(in_code, in_a, in_b);
        if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
        if (in_last) begin
          m_q.push_back('{data: m_sum, cnt: m_cnt});
          m_sum = '0;
          m_cnt = '0;
          pending = 1'b1;
          last_cyc = cyc;
        end
      end
    end
  end

  // Called just after a posedge; returns just after the posedge that took the beat.
  task automatic send(input logic [1:0] c, input logic [OP_W-1:0] a,
                      input logic [OP_W-1:0] b, input logic l);
    int  w;
    bit  took;
    in_valid = 1'b1;
    in_code  = c;
    in_a     = a;
    in_b     = b;
    in_last  = l;
    w = 0;
    took = 1'b0;
    while (!took && w < 50) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      w++;
    end
    if (!took) chk("send_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [ACC_BIT-1:0] exp_d,
                             input logic [CNT_BIT-1:0] exp_c);
    int w;
    bit seen;
    w = 0;
    seen = 1'b0;
    while (!seen && w < 20) begin
      @(negedge clk);
      seen = res_valid;
      w++;
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 64'(0), 64'(1));
    end else begin
      chk({tag, "_data"}, 64'(res_data), 64'(exp_d));
      chk({tag, "_count"}, 64'(res_count), 64'(exp_c));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_code   = 2'b11;
    in_a      = '1;
    in_b      = '1;
    in_last   = 1'b1;
    res_ready = 1'b1;

    // Reset held with a valid beat offered
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", 64'(in_ready), 64'(0));
      chk("reset_res_valid", 64'(res_valid), 64'(0));
      chk("reset_mac_ctrl", 64'(mac_ctrl), 64'(0));
      chk("reset_res_data", 64'(res_data), 64'(0));
    end
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Mixed vector, result held under backpressure
    res_ready = 1'b0;
    send(2'b01, 16'd5, 16'd0, 1'b0);
    send(2'b10, 16'd3, 16'd0, 1'b0);
    send(2'b00, 16'd7, 16'd0, 1'b0);
    send(2'b11, 16'h0010, 16'h0003, 1'b1);
    @(negedge clk);
    chk("mixed_flush_valid", 64'(res_valid), 64'(0));
    @(negedge clk);
    chk("mixed_valid", 64'(res_valid), 64'(1));
    chk("mixed_data", 64'(res_data), 64'd50);
    chk("mixed_count", 64'(res_count), 64'd4);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_code  = 2'b01;
    in_a     = 16'd2;
    in_b     = 16'd0;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_data", 64'(res_data), 64'd50);
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_valid", 64'(res_valid), 64'(1));
      @(posedge clk);
      #1;
    end
    res_ready = 1'b1;
    send(2'b01, 16'd2, 16'd0, 1'b1);
    wait_result("after_bp", 40'd2, 16'd1);

    // Single-beat sign and zero extension
    send(2'b10, 16'h0001, 16'h0000, 1'b1);
    wait_result("sign_ext", 40'hFF_FFFF_FFFF, 16'd1);
    send(2'b11, 16'hFFFF, 16'hFFFF, 1'b1);
    wait_result("zero_ext", 40'h00_FFFE_0001, 16'd1);

    // Reset in the middle of a vector
    send(2'b01, 16'd4, 16'd0, 1'b0);
    send(2'b01, 16'd4, 16'd0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    send(2'b01, 16'd9, 16'd0, 1'b1);
    wait_result("mid_reset", 40'd9, 16'd1);

    // Random traffic with occasional resets and backpressure
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_code   = 2'($urandom_range(0, 3));
      in_a      = OP_W'($urandom);
      in_b      = OP_W'($urandom);
      in_last   = ($urandom_range(0, 4) == 0);
      res_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    reset     = 1'b1;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("drain_queue_empty", 64'(m_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
